// File: rtl/rainbow_pkg.sv
// Shared constants for the rainbow breathing LED key path.
// State encoding and 50 MHz default timing.
package rainbow_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DOWN1 = 2'd1;
  localparam logic [1:0] ST_WAIT2 = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int unsigned LONG_CYC_DEF = 25_000_000;
  localparam int unsigned DBL_CYC_DEF  = 12_500_000;
  localparam int unsigned SPD_DEF_DEF  = 3;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/evt_timer.sv
// Clearable up-counter with a terminal-count compare.
// Counts only while enabled; clear has priority.
module evt_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] cmp_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == cmp_i);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key presses into PRESS/RELEASE/SHORT/LONG/DOUBLE
// pulses and owns the SPEED/MODE user state of the breathing LED.
module key_event_decoder
  import rainbow_pkg::*;
#(
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter int unsigned DBL_CYC    = DBL_CYC_DEF,
  parameter int unsigned SPD_W      = 3,
  parameter int unsigned SPD_LEVELS = 8,
  parameter int unsigned SPD_DEF    = SPD_DEF_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             KP,
  output logic             PRESS,
  output logic             RELEASE,
  output logic             SHORT,
  output logic             LONG,
  output logic             DOUBLE,
  output logic [SPD_W-1:0] SPEED,
  output logic             MODE
);

  localparam int unsigned TW =
    $clog2(max_u(LONG_CYC, DBL_CYC));

  localparam logic [TW-1:0] LONG_TC = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] DBL_TC  = TW'(DBL_CYC - 1);
  localparam logic [SPD_W-1:0] SPD_RST = SPD_W'(SPD_DEF);
  localparam logic [SPD_W-1:0] SPD_TOP = SPD_W'(SPD_LEVELS - 1);

  logic             kp_q;
  logic [1:0]       state_q, state_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic [SPD_W-1:0] speed_q, speed_d;
  logic             mode_q, mode_d;

  logic          fall;
  logic          rise;
  logic          tc;
  logic          tmr_clr;
  logic          tmr_en;
  logic [TW-1:0] tmr_cmp;

  // kp_q resets low so a key held through reset never looks like a fall
  assign fall = kp_q & ~KP;
  assign rise = ~kp_q & KP;

  assign tmr_en  = (state_q == ST_DOWN1) | (state_q == ST_WAIT2);
  assign tmr_clr = (state_d != state_q);
  assign tmr_cmp = (state_q == ST_DOWN1) ? LONG_TC : DBL_TC;

  evt_timer #(
    .W (TW)
  ) u_tmr (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .cmp_i (tmr_cmp),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    speed_d = speed_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_DOWN1;
          press_d = 1'b1;
        end
      end
      ST_DOWN1: begin
        if (rise) begin
          state_d = ST_WAIT2;
          rel_d   = 1'b1;
        end else if (tc) begin
          state_d = ST_HOLD;
          long_d  = 1'b1;
          speed_d = SPD_RST;
        end
      end
      ST_WAIT2: begin
        if (fall) begin
          state_d = ST_HOLD;
          press_d = 1'b1;
          dbl_d   = 1'b1;
          mode_d  = ~mode_q;
        end else if (tc) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
          speed_d = (speed_q == SPD_TOP) ? '0
                    : speed_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (rise) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      kp_q    <= 1'b0;
      state_q <= ST_IDLE;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      speed_q <= SPD_RST;
      mode_q  <= 1'b0;
    end else begin
      kp_q    <= KP;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      speed_q <= speed_d;
      mode_q  <= mode_d;
    end
  end

  assign PRESS   = press_q;
  assign RELEASE = rel_q;
  assign SHORT   = short_q;
  assign LONG    = long_q;
  assign DOUBLE  = dbl_q;
  assign SPEED   = speed_q;
  assign MODE    = mode_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed key scripts plus random
// press/release durations, checked every cycle against a timestamp model.
module tb_key_event_decoder;

  localparam int LC  = 20;
  localparam int DC  = 10;
  localparam int LV  = 8;
  localparam int DEF = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       KP  = 1'b1;
  logic       PRESS, RELEASE, SHORT, LONG, DOUBLE;
  logic [2:0] SPEED;
  logic       MODE;

  int n_chk = 0;
  int n_err = 0;

  // reference model: sequence phase plus event timestamps
  int cyc = 0;
  int seq = 0;
  int t0  = 0;
  int t1  = 0;
  bit p   = 1'b0;
  int m_speed = DEF;
  int m_mode  = 0;

  always #5 CLK = ~CLK;

  key_event_decoder #(
    .LONG_CYC   (LC),
    .DBL_CYC    (DC),
    .SPD_W      (3),
    .SPD_LEVELS (LV),
    .SPD_DEF    (DEF)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .KP      (KP),
    .PRESS   (PRESS),
    .RELEASE (RELEASE),
    .SHORT   (SHORT),
    .LONG    (LONG),
    .DOUBLE  (DOUBLE),
    .SPEED   (SPEED),
    .MODE    (MODE)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit k, r, fall, rise;
    bit e_pr, e_rl, e_sh, e_lg, e_db;
    k = KP;
    r = RST;
    e_pr = 0; e_rl = 0; e_sh = 0; e_lg = 0; e_db = 0;
    @(posedge CLK);
    cyc++;
    if (r) begin
      p = 0; seq = 0; m_speed = DEF; m_mode = 0;
    end else begin
      fall = p & ~k;
      rise = ~p & k;
      p = k;
      case (seq)
        0: if (fall) begin
          seq = 1; t0 = cyc; e_pr = 1;
        end
        1: if (rise) begin
          seq = 2; t1 = cyc; e_rl = 1;
        end else if (cyc - t0 == LC) begin
          seq = 3; e_lg = 1; m_speed = DEF;
        end
        2: if (fall) begin
          seq = 3; e_pr = 1; e_db = 1; m_mode = 1 - m_mode;
        end else if (cyc - t1 == DC) begin
          seq = 0; e_sh = 1; m_speed = (m_speed + 1) % LV;
        end
        default: if (rise) begin
          seq = 0; e_rl = 1;
        end
      endcase
    end
    #1;
    check("pulses", {PRESS, RELEASE, SHORT, LONG, DOUBLE},
          {e_pr, e_rl, e_sh, e_lg, e_db});
    check("speed", int'(SPEED), m_speed);
    check("mode", int'(MODE), m_mode);
    check("excl", int'($countones({SHORT, LONG, DOUBLE}) <= 1), 1);
  endtask

  task automatic hold(input bit lvl, input int n);
    KP = lvl;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tap(input int lo, input int hi);
    hold(1'b0, lo);
    hold(1'b1, hi);
  endtask

  initial begin
    RST = 1'b1;
    KP  = 1'b1;
    for (int i = 0; i < 3; i++) step();
    RST = 1'b0;

    hold(1'b1, 50);
    check("rst_speed", int'(SPEED), DEF);
    check("rst_mode", int'(MODE), 0);

    tap(5, 15);
    check("short_speed", int'(SPEED), 4);

    tap(30, 15);
    check("long_speed", int'(SPEED), DEF);

    for (int r = 0; r < 2; r++) begin
      tap(3, 4);
      tap(3, 15);
    end
    check("dbl_mode", int'(MODE), 0);

    for (int i = 0; i < 5; i++) tap(2, 12);
    check("wrap_speed", int'(SPEED), 0);

    tap(LC, 15);
    tap(3, DC);
    tap(3, 15);

    hold(1'b0, 5);
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    hold(1'b0, 10);
    hold(1'b1, 5);
    tap(3, 15);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 30) == 0) begin
        RST = 1'b1;
        step();
        RST = 1'b0;
      end
      tap($urandom_range(1, 25), $urandom_range(1, 14));
    end
    hold(1'b1, 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
